// File: rtl/vlg_debounce_pkg.sv
// Shared debounce definitions: FSM state encoding, state width and default qualification length.
package vlg_debounce_pkg;

  localparam int STATE_W               = 2;
  localparam int DEFAULT_STABLE_CYCLES = 1_000_000;

  typedef enum logic [STATE_W-1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; 2-cycle latency, no backpressure.
// Reset loads P_RST_VAL into both flops so the output reads as a known idle level out of reset.
module sync_2ff #(
  parameter bit P_RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= P_RST_VAL;
      sync_q <= P_RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/key_debounce.sv
// Key debouncer: stability counter + 4-state FSM, level accepted after P_STABLE_CYCLES stable cycles.
// Optional input synchronizer under KEY_DEBOUNCE_SYNC_EN (adds 2 cycles of latency).
module key_debounce
  import vlg_debounce_pkg::*;
#(
  parameter int P_STABLE_CYCLES  = DEFAULT_STABLE_CYCLES,
  parameter bit P_KEY_ACTIVE_LOW = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  output logic o_key_level,
  output logic o_busy
);

  localparam int CNT_W = (P_STABLE_CYCLES > 1) ? $clog2(P_STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(P_STABLE_CYCLES - 1);

  logic key_sync;
  logic key_on;

`ifdef KEY_DEBOUNCE_SYNC_EN
  sync_2ff #(
    .P_RST_VAL(P_KEY_ACTIVE_LOW)
  ) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_key),
    .o_q    (key_sync)
  );
`else
  assign key_sync = i_key;
`endif

  assign key_on = key_sync ^ P_KEY_ACTIVE_LOW;

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             key_level_d, key_level_q;
  logic             busy_d, busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RELEASED: begin
        if (key_on) begin
          state_d = S_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!key_on) begin
          state_d = S_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PRESSED: begin
        if (!key_on) begin
          state_d = S_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (key_on) begin
          state_d = S_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_RELEASED;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    key_level_d = (state_d == S_PRESSED) || (state_d == S_RELEASE_WAIT);
    busy_d      = (state_d == S_PRESS_WAIT) || (state_d == S_RELEASE_WAIT);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_RELEASED;
      cnt_q       <= '0;
      key_level_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_level_q <= key_level_d;
      busy_q      <= busy_d;
    end
  end

  assign o_key_level = key_level_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_key_debounce.sv
// Randomized + directed bench for key_debounce with a run-length reference model and a
// decoupled scoreboard (model pushes expected outputs, monitor pops and compares).
module tb_key_debounce;

  localparam int P = 4;
`ifdef KEY_DEBOUNCE_SYNC_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 0;
`endif

  typedef struct packed {
    logic lvl;
    logic busy;
  } exp_t;

  logic clk;
  logic rst_n;
  logic key_lo;
  logic key_hi;
  logic lvl_lo, busy_lo;
  logic lvl_hi, busy_hi;

  int n_cmp;
  int n_err;

  exp_t q_lo[$];
  exp_t q_hi[$];
  exp_t q_rst[$];
  event rst_ev;

  key_debounce #(.P_STABLE_CYCLES(P), .P_KEY_ACTIVE_LOW(1'b1)) u_dut_lo (
    .i_clk(clk), .i_rst_n(rst_n), .i_key(key_lo),
    .o_key_level(lvl_lo), .o_busy(busy_lo)
  );

  key_debounce #(.P_STABLE_CYCLES(P), .P_KEY_ACTIVE_LOW(1'b0)) u_dut_hi (
    .i_clk(clk), .i_rst_n(rst_n), .i_key(key_hi),
    .o_key_level(lvl_hi), .o_busy(busy_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the level flips once the pressed/released view has disagreed with it
  // for P+1 consecutive clock edges; busy means a disagreement run is in progress.
  bit m_lvl[2];
  int m_run[2];
  bit m_hist[2][$];

  function automatic bit model_step(input int i, input bit raw, input bit act_low);
    bit eff;
    bit on;
    m_hist[i].push_back(raw);
    eff = m_hist[i].pop_front();
    on  = eff ^ act_low;
    if (on != m_lvl[i]) begin
      m_run[i]++;
      if (m_run[i] == P + 1) begin
        m_lvl[i] = ~m_lvl[i];
        m_run[i] = 0;
      end
    end else begin
      m_run[i] = 0;
    end
    return m_run[i] != 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 1'b0;
      m_run[i] = 0;
      m_hist[i].delete();
      // Pipeline history holds the inactive raw level of each instance.
      for (int d = 0; d < SYNC_DEPTH; d++) m_hist[i].push_back(i == 0);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      exp_t e;
      e.busy = model_step(0, key_lo, 1'b1);
      e.lvl  = m_lvl[0];
      q_lo.push_back(e);
      e.busy = model_step(1, key_hi, 1'b0);
      e.lvl  = m_lvl[1];
      q_hi.push_back(e);
    end
  end

  task automatic check(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    while (q_lo.size() > 0) begin
      exp_t e;
      e = q_lo.pop_front();
      check("lo_level", lvl_lo, e.lvl);
      check("lo_busy", busy_lo, e.busy);
    end
    while (q_hi.size() > 0) begin
      exp_t e;
      e = q_hi.pop_front();
      check("hi_level", lvl_hi, e.lvl);
      check("hi_busy", busy_hi, e.busy);
    end
  end

  always @(rst_ev) begin
    while (q_rst.size() > 0) begin
      exp_t e;
      e = q_rst.pop_front();
      check("rst_lo_level", lvl_lo, e.lvl);
      check("rst_lo_busy", busy_lo, e.busy);
      check("rst_hi_level", lvl_hi, e.lvl);
      check("rst_hi_busy", busy_hi, e.busy);
    end
  end

  // key_lo is active-low raw; key_hi is driven with the same logical press pattern, active-high.
  task automatic hold(input bit pressed, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      key_lo = ~pressed;
      key_hi = pressed;
    end
  endtask

  task automatic reset_check_now();
    exp_t e;
    rst_n = 1'b0;
    #1;
    e.lvl  = 1'b0;
    e.busy = 1'b0;
    q_rst.push_back(e);
    ->rst_ev;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    key_lo = 1'b1;
    key_hi = 1'b0;
    rst_n  = 1'b1;
    model_reset();
    #2;
    reset_check_now();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    hold(1'b0, 4);
    // Clean press, then release with a short re-press glitch that must abort.
    hold(1'b1, 12);
    hold(1'b0, 3);
    hold(1'b1, 3);
    hold(1'b0, 12);
    // Bounce on press: 2-cycle toggles then a steady hold.
    hold(1'b1, 2);
    hold(1'b0, 2);
    hold(1'b1, 2);
    hold(1'b0, 2);
    hold(1'b1, 12);
    hold(1'b0, 12);

    // Reset mid-qualification with the key kept pressed throughout.
    hold(1'b1, SYNC_DEPTH + 3);
    @(posedge clk);
    #3;
    reset_check_now();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 12);
    hold(1'b0, 12);

    for (int s = 0; s < 300; s++) begin
      bit v;
      v = 1'($urandom_range(0, 1));
      hold(v, int'($urandom_range(1, 8)));
      if (s == 150) begin
        @(posedge clk);
        #2;
        reset_check_now();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    hold(1'b0, 12);

    @(posedge clk);
    #3;
    n_cmp++;
    if (q_lo.size() != 0 || q_hi.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d entries left, expected 0", q_lo.size(), q_hi.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
